// File: rtl/binary_filter_pkg.sv
// Shared types and timing helper for the binary window filter.
// Used by the filter top, its tap generator and any stage that needs to predict write timing.
package binary_filter_pkg;

  typedef enum logic [1:0] {
    EDGE_CLAMP = 2'd0,
    EDGE_ZERO  = 2'd1,
    EDGE_COPY  = 2'd2
  } edge_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } filter_state_t;

  // Cycles spent on each output pixel: one read per tap, the read latency, one write.
  function automatic int unsigned pixel_period(input int unsigned k,
                                               input int unsigned read_latency);
    return k * k + read_latency + 1;
  endfunction

endpackage

// File: rtl/window_tap_gen.sv
// Combinational tap address generator: maps a window center plus tap index to a
// framebuffer address, with clamping, range detection and center-tap detection.
module window_tap_gen
  import binary_filter_pkg::*;
#(
  parameter int WIDTH      = 480,
  parameter int HEIGHT     = 480,
  parameter int K          = 3,
  parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT),
  parameter int XW         = $clog2(WIDTH),
  parameter int YW         = $clog2(HEIGHT),
  parameter int TW         = $clog2(K)
) (
  input  logic [XW-1:0]         center_x,
  input  logic [YW-1:0]         center_y,
  input  logic [TW-1:0]         tap_dx,
  input  logic [TW-1:0]         tap_dy,
  input  edge_mode_t            edge_mode,
  output logic [ADDR_WIDTH-1:0] tap_addr,
  output logic                  in_range,
  output logic                  is_center
);

  localparam int R   = (K - 1) / 2;
  // Signed coordinates must hold -R .. WIDTH-1+R, hence the extra headroom.
  localparam int SXW = $clog2(WIDTH + K) + 1;
  localparam int SYW = $clog2(HEIGHT + K) + 1;

  logic signed [SXW-1:0] sx;
  logic signed [SXW-1:0] clx;
  logic signed [SYW-1:0] sy;
  logic signed [SYW-1:0] cly;
  logic                  x_ok;
  logic                  y_ok;
  logic [XW-1:0]         ux;
  logic [YW-1:0]         uy;

  always_comb begin
    sx  = $signed(SXW'(center_x)) + $signed(SXW'(tap_dx)) - $signed(SXW'(R));
    sy  = $signed(SYW'(center_y)) + $signed(SYW'(tap_dy)) - $signed(SYW'(R));
    x_ok = !sx[SXW-1] && (sx <= $signed(SXW'(WIDTH - 1)));
    y_ok = !sy[SYW-1] && (sy <= $signed(SYW'(HEIGHT - 1)));
    clx = sx[SXW-1] ? '0 : (x_ok ? sx : $signed(SXW'(WIDTH - 1)));
    cly = sy[SYW-1] ? '0 : (y_ok ? sy : $signed(SYW'(HEIGHT - 1)));
    ux  = XW'(clx);
    uy  = YW'(cly);
    in_range  = x_ok && y_ok;
    is_center = (tap_dx == TW'(R)) && (tap_dy == TW'(R));
    tap_addr  = ADDR_WIDTH'(uy) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(ux);
    if (edge_mode == EDGE_ZERO && !in_range) begin
      tap_addr = '0;
    end
  end

endmodule

// File: rtl/binary_window_filter.sv
// KxK binary window filter: walks a binarized frame in raster order, counts ones
// around each pixel and writes (count > threshold) or the center pixel to an output BRAM.
module binary_window_filter
  import binary_filter_pkg::*;
#(
  parameter int WIDTH        = 480,
  parameter int HEIGHT       = 480,
  parameter int K            = 3,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(WIDTH * HEIGHT),
  parameter int CNT_WIDTH    = $clog2(K * K + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [CNT_WIDTH-1:0]  threshold_in,
  input  logic [1:0]            edge_mode_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic                  rd_data_in,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic                  wr_data_out,
  output logic                  wr_valid_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int TW = $clog2(K);
  localparam int DW = $clog2(READ_LATENCY + 1);

  filter_state_t            state;
  edge_mode_t               mode_q;
  logic [CNT_WIDTH-1:0]     thr_q;
  logic [CNT_WIDTH-1:0]     acc;
  logic [CNT_WIDTH-1:0]     acc_next;
  logic                     center_val;
  logic                     center_next;
  logic                     oor_q;
  logic [XW-1:0]            cx;
  logic [YW-1:0]            cy;
  logic [TW-1:0]            tx;
  logic [TW-1:0]            ty;
  logic [DW-1:0]            drain_cnt;
  logic [READ_LATENCY-1:0]  tag_vld_p;
  logic [READ_LATENCY-1:0]  tag_ctr_p;

  logic [ADDR_WIDTH-1:0]    tap_addr;
  logic                     tap_in_range;
  logic                     tap_is_center;
  logic                     issue;
  logic                     issue_vld;
  logic                     issue_ctr;
  logic                     last_tap;
  logic                     result;
  logic [ADDR_WIDTH-1:0]    center_addr;

  window_tap_gen #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .K          (K),
    .ADDR_WIDTH (ADDR_WIDTH),
    .XW         (XW),
    .YW         (YW),
    .TW         (TW)
  ) u_tap_gen (
    .center_x  (cx),
    .center_y  (cy),
    .tap_dx    (tx),
    .tap_dy    (ty),
    .edge_mode (mode_q),
    .tap_addr  (tap_addr),
    .in_range  (tap_in_range),
    .is_center (tap_is_center)
  );

  // Issue stage: one tap address per cycle, tagged for the return path.
  always_comb begin
    issue       = (state == ST_ISSUE);
    rd_addr_out = issue ? tap_addr : '0;
    issue_vld   = issue && (tap_in_range || mode_q != EDGE_ZERO);
    issue_ctr   = issue && tap_is_center;
    last_tap    = (tx == TW'(K - 1)) && (ty == TW'(K - 1));
    center_addr = ADDR_WIDTH'(cy) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(cx);
  end

  // Return stage: tags emerge aligned with rd_data_in; the final tap is folded in
  // combinationally so the result is ready on the last DRAIN cycle.
  always_comb begin
    acc_next    = acc + CNT_WIDTH'(tag_vld_p[READ_LATENCY-1] & rd_data_in);
    center_next = tag_ctr_p[READ_LATENCY-1] ? rd_data_in : center_val;
    result      = (mode_q == EDGE_COPY && oor_q) ? center_next : (acc_next > thr_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      mode_q       <= EDGE_CLAMP;
      thr_q        <= '0;
      acc          <= '0;
      center_val   <= 1'b0;
      oor_q        <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      tx           <= '0;
      ty           <= '0;
      drain_cnt    <= '0;
      tag_vld_p    <= '0;
      tag_ctr_p    <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= 1'b0;
      wr_valid_out <= 1'b0;
    end else begin
      wr_valid_out <= 1'b0;
      done_out     <= 1'b0;
      tag_vld_p    <= (tag_vld_p << 1) | READ_LATENCY'(issue_vld);
      tag_ctr_p    <= (tag_ctr_p << 1) | READ_LATENCY'(issue_ctr);
      acc          <= acc_next;
      center_val   <= center_next;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            thr_q    <= threshold_in;
            mode_q   <= (edge_mode_in == 2'd3) ? EDGE_CLAMP : edge_mode_t'(edge_mode_in);
            cx       <= '0;
            cy       <= '0;
            tx       <= '0;
            ty       <= '0;
            busy_out <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!tap_in_range) begin
            oor_q <= 1'b1;
          end
          if (last_tap) begin
            tx        <= '0;
            ty        <= '0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else if (tx == TW'(K - 1)) begin
            tx <= '0;
            ty <= ty + 1'b1;
          end else begin
            tx <= tx + 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DW'(READ_LATENCY - 1)) begin
            wr_valid_out <= 1'b1;
            wr_addr_out  <= center_addr;
            wr_data_out  <= result;
            state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          acc        <= '0;
          center_val <= 1'b0;
          oor_q      <= 1'b0;
          state      <= ST_ISSUE;
          if (cx == XW'(WIDTH - 1)) begin
            cx <= '0;
            if (cy == YW'(HEIGHT - 1)) begin
              cy       <= '0;
              done_out <= 1'b1;
              state    <= ST_DONE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        ST_DONE: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_window_filter.sv
// Scoreboard bench for binary_window_filter on an 8x4 frame: K=3/RL=2 and K=5/RL=3 instances.
module tb_binary_window_filter;
  import binary_filter_pkg::*;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int AW  = $clog2(N);
  localparam int K1  = 3;
  localparam int RL1 = 2;
  localparam int P1  = pixel_period(K1, RL1);
  localparam int CW1 = $clog2(K1 * K1 + 1);
  localparam int K2  = 5;
  localparam int RL2 = 3;
  localparam int P2  = pixel_period(K2, RL2);
  localparam int CW2 = $clog2(K2 * K2 + 1);

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic           start1 = 1'b0;
  logic [CW1-1:0] thr1 = '0;
  logic [1:0]     mode1 = '0;
  logic           busy1, done1, rd_data1, wr_data1, wr_valid1;
  logic [AW-1:0]  rd_addr1, wr_addr1;
  logic           start2 = 1'b0;
  logic [CW2-1:0] thr2 = '0;
  logic [1:0]     mode2 = '0;
  logic           busy2, done2, rd_data2, wr_data2, wr_valid2;
  logic [AW-1:0]  rd_addr2, wr_addr2;

  bit             img [N];
  logic [RL1-1:0] pipe1 = '0;
  logic [RL2-1:0] pipe2 = '0;

  typedef struct {
    int addr;
    bit data;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   dq1[$];
  int   dq2[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  binary_window_filter #(.WIDTH(W), .HEIGHT(H), .K(K1), .READ_LATENCY(RL1)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start1), .threshold_in(thr1),
    .edge_mode_in(mode1), .busy_out(busy1), .done_out(done1), .rd_addr_out(rd_addr1),
    .rd_data_in(rd_data1), .wr_addr_out(wr_addr1), .wr_data_out(wr_data1),
    .wr_valid_out(wr_valid1)
  );

  binary_window_filter #(.WIDTH(W), .HEIGHT(H), .K(K2), .READ_LATENCY(RL2)) u_big (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start2), .threshold_in(thr2),
    .edge_mode_in(mode2), .busy_out(busy2), .done_out(done2), .rd_addr_out(rd_addr2),
    .rd_data_in(rd_data2), .wr_addr_out(wr_addr2), .wr_data_out(wr_data2),
    .wr_valid_out(wr_valid2)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM models with the configured read latency.
  always @(posedge clk_in) begin
    pipe1 <= {pipe1[RL1-2:0], img[rd_addr1]};
    pipe2 <= {pipe2[RL2-2:0], img[rd_addr2]};
  end
  assign rd_data1 = pipe1[RL1-1];
  assign rd_data2 = pipe2[RL2-1];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit img_val(input int scen, input int x, input int y);
    case (scen)
      3:       return (x == 3 && y == 1);
      4:       return ((x + y) % 2) == 1;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_val(input int scen, input int x, input int y);
    int  ones3[9] = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
    bit  border = (x == 0 || x == W - 1 || y == 0 || y == H - 1);
    bit  hit = 1'b0;
    case (scen)
      2: return !((x == 0 || x == W - 1) && (y == 0 || y == H - 1));
      3: begin
        foreach (ones3[i]) if (ones3[i] == x + y * W) hit = 1'b1;
        return hit;
      end
      4: return border ? img_val(4, x, y) : 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    if (wr_valid1) begin
      check("pending_write1", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("wr_addr1", int'(wr_addr1), e.addr);
        check("wr_data1", int'(wr_data1), int'(e.data));
        check("wr_cycle1", cyc, e.cyc);
      end
    end
    if (done1) begin
      check("pending_done1", int'(dq1.size() > 0), 1);
      if (dq1.size() > 0) check("done_cycle1", cyc, dq1.pop_front());
    end
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (wr_valid2) begin
      check("pending_write2", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("wr_addr2", int'(wr_addr2), e.addr);
        check("wr_data2", int'(wr_data2), int'(e.data));
        check("wr_cycle2", cyc, e.cyc);
      end
    end
    if (done2) begin
      check("pending_done2", int'(dq2.size() > 0), 1);
      if (dq2.size() > 0) check("done_cycle2", cyc, dq2.pop_front());
    end
  end

  task automatic check_idle1(input string tag);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_done"}, int'(done1), 0);
    check({tag, "_wr_valid"}, int'(wr_valid1), 0);
    check({tag, "_wr_addr"}, int'(wr_addr1), 0);
    check({tag, "_wr_data"}, int'(wr_data1), 0);
    check({tag, "_rd_addr"}, int'(rd_addr1), 0);
  endtask

  task automatic run_frame(input int scen, input int thr, input int mode,
                           input bit restart, input int abort_at);
    int c0;
    for (int a = 0; a < N; a++) img[a] = img_val(scen, a % W, a / W);
    @(posedge clk_in); #1;
    start1 = 1'b1;
    thr1   = CW1'(thr);
    mode1  = 2'(mode);
    c0     = cyc;
    for (int n = 0; n < N; n++) q1.push_back('{n, exp_val(scen, n % W, n / W), c0 + (n + 1) * P1});
    dq1.push_back(c0 + N * P1 + 1);
    for (int i = 1; i <= N * P1 + 2; i++) begin
      @(posedge clk_in); #1;
      start1 = restart && (i == 50);
      if (restart && i == 100) begin
        thr1  = CW1'(9);
        mode1 = 2'd1;
      end
      if (i == abort_at) begin
        #2 rst_in = 1'b1;
        #1 check_idle1("abort");
        q1.delete();
        dq1.delete();
        @(posedge clk_in); #1 rst_in = 1'b0;
        return;
      end
      if (i == 1) check("busy_after_start", int'(busy1), 1);
      if (i == N * P1 + 1) check("busy_in_done", int'(busy1), 1);
      if (i == N * P1 + 2) check("busy_after_done", int'(busy1), 0);
    end
  endtask

  task automatic run_big();
    int c0;
    for (int a = 0; a < N; a++) img[a] = 1'b1;
    @(posedge clk_in); #1;
    start2 = 1'b1;
    thr2   = CW2'(4);
    mode2  = 2'd0;
    c0     = cyc;
    for (int n = 0; n < N; n++) q2.push_back('{n, 1'b1, c0 + (n + 1) * P2});
    dq2.push_back(c0 + N * P2 + 1);
    for (int i = 1; i <= N * P2 + 2; i++) begin
      @(posedge clk_in); #1;
      start2 = 1'b0;
      if (i == N * P2 + 1) check("busy2_in_done", int'(busy2), 1);
      if (i == N * P2 + 2) check("busy2_after_done", int'(busy2), 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1 check_idle1("reset");
    check("reset_busy2", int'(busy2), 0);
    check("reset_wr_valid2", int'(wr_valid2), 0);
    rst_in = 1'b0;

    run_frame(1, 4, 0, 1'b0, 0);   // all ones, CLAMP
    run_frame(2, 4, 1, 1'b0, 0);   // all ones, ZERO: corners drop out
    run_frame(3, 0, 1, 1'b0, 0);   // single pixel spreads to its 3x3 neighbourhood
    run_frame(4, 8, 2, 1'b0, 0);   // checkerboard, COPY on the border
    run_frame(1, 4, 0, 1'b1, 0);   // restart and threshold change ignored mid-frame
    run_frame(1, 4, 0, 1'b0, 64);  // reset during ISSUE of pixel 5
    run_frame(1, 4, 0, 1'b0, 0);   // clean frame after the abort
    run_big();

    repeat (3) @(posedge clk_in);
    #1;
    check("leftover_writes1", q1.size(), 0);
    check("leftover_done1", dq1.size(), 0);
    check("leftover_writes2", q2.size(), 0);
    check("leftover_done2", dq2.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/binary_window_filter.md
Name: binary_window_filter

Overview:
- Parametrised successor to the fixed 3x3 binary averaging stage.
- Walks every pixel of a binarized framebuffer in raster order and counts the ones in a KxK window around each pixel.
- Writes the thresholded result (count > threshold) to an output BRAM.
- Adds a run-time threshold, selectable edge handling, a configurable BRAM read latency, and a start/busy/done handshake. It sits between the binarizing framebuffer and the QR finder stage.

Parameters:
- WIDTH, 480, image width in pixels
- HEIGHT, 480, image height in pixels
- K, 3, window side length; odd, 3..7
- READ_LATENCY, 2, cycles from rd_addr_out to valid rd_data_in; 1..4
- ADDR_WIDTH, $clog2(WIDTH*HEIGHT), pixel address width
- CNT_WIDTH, $clog2(K*K+1), window count / threshold width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- start_in  input  1  begin frame; honoured only in IDLE
- threshold_in  input  CNT_WIDTH  output is 1 when count > threshold; sampled on accepted start
- edge_mode_in  input  2  0=CLAMP, 1=ZERO, 2=COPY, 3=reserved (treated as CLAMP); sampled on accepted start
- busy_out  output  1  high from the cycle after an accepted start through the DONE cycle
- done_out  output  1  one-cycle pulse in the DONE state
- rd_addr_out  output  ADDR_WIDTH  source framebuffer read address
- rd_data_in  input  1  source pixel; valid READ_LATENCY cycles after its address
- wr_addr_out  output  ADDR_WIDTH  destination address (x + y*WIDTH)
- wr_data_out  output  1  filtered pixel
- wr_valid_out  output  1  write strobe, one cycle per pixel

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs, counters, accumulator and latched config cleared to 0. No done pulse is produced for an aborted frame.
- States: IDLE -> ISSUE -> DRAIN -> WRITE -> (ISSUE for the next pixel | DONE) -> IDLE.
- IDLE:
  - start_in=1 latches threshold and edge mode, sets center=(0,0) and tap=(0,0), then goes to ISSUE.
  - start_in while not in IDLE is ignored.
- ISSUE: exactly K*K cycles, one tap per cycle in row-major order (dy=-R..R, dx=-R..R, R=(K-1)/2). Each cycle drives rd_addr_out for that tap.
  - CLAMP: out-of-range coordinates are clamped to [0,WIDTH-1] / [0,HEIGHT-1], then read.
  - ZERO: out-of-range taps still take a cycle and drive address 0, but are tagged invalid and contribute 0.
  - COPY: taps are read as in CLAMP. If any tap of the window is out of range, the output equals the center tap value instead of the threshold result.
- Return path: a READ_LATENCY-deep shift register of (tap valid, is_center) tags aligns with rd_data_in. The accumulator adds rd_data_in when the tag is valid; the center value is captured when is_center is set.
- DRAIN: READ_LATENCY cycles. The last tap's data arrives in the final DRAIN cycle.
- WRITE: one cycle.
  - wr_valid_out=1, wr_addr_out=center address, wr_data_out=result.
  - Accumulator is cleared and center advances (x wraps WIDTH-1 -> 0 with y+1).
  - After pixel (WIDTH-1, HEIGHT-1), the next state is DONE.
- Timing:
  - Per-pixel period = K*K + READ_LATENCY + 1 cycles.
  - With the accepted start in cycle 0, the WRITE for pixel n is in cycle (n+1)*P.
  - DONE follows in the next cycle and returns to IDLE after one cycle.
- wr_valid_out and done_out are 0 in every other cycle. wr_addr_out and wr_data_out hold their last values.
- The count never overflows: CNT_WIDTH holds K*K. Compare unsigned.
- Coordinate arithmetic uses signed widths 1 bit wider than needed for the x/y range. Address multiply is y*WIDTH.

Decomposition:
- Shared package binary_filter_pkg: edge_mode_t enum (EDGE_CLAMP, EDGE_ZERO, EDGE_COPY), filter_state_t enum, and a function computing the per-pixel period.
- Sub-module window_tap_gen: given center, tap index and edge mode, combinationally produces the tap address, in_range flag and is_center flag.

Test Plan (WIDTH=8, HEIGHT=4, K=3, READ_LATENCY=2, P=12; the bench models the BRAM latency):
1. All-ones frame, threshold 4, CLAMP, start at cycle 0 -> 32 writes, all 1, addresses 0..31 in order, at cycles 12, 24, ..., 384. done_out pulses at cycle 385, busy_out low at 386.
2. All-ones frame, threshold 4, ZERO -> corners (addresses 0, 7, 24, 31) = 0 (count 4); other border pixels = 1 (count 6); interior = 1.
3. Single 1 at (3,1), threshold 0, ZERO -> wr_data_out=1 exactly at addresses 2, 3, 4, 10, 11, 12, 18, 19, 20; all others 0.
4. Checkerboard, threshold 8, COPY -> all border pixels equal their own input value; interior pixels all 0.
5. start_in pulsed again at cycle 50, and threshold_in changed mid-frame -> no restart, write timing unchanged, results use the original threshold.
6. rst_in asserted asynchronously during ISSUE of pixel 5 -> all outputs 0 immediately, no done pulse. A new start then completes all 32 writes with the standard timing; repeat scenario 1 with K=5, READ_LATENCY=3 -> P=29.
